// File: rtl/fdivsqrt_r4_seq.sv
// Radix-4 divide/sqrt iteration sequencer: runs the step count, keeps the
// on-the-fly converted result registers U/UM and the digit position mask C.
module fdivsqrt_r4_seq #(
  parameter int unsigned DIVb = 64,
  parameter int unsigned CNTW = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sqrt_e_i,
  input  logic [CNTW-1:0] num_iter_i,
  input  logic            flush_i,
  input  logic [3:0]      udigit_i,
  output logic            busy_o,
  output logic            step_o,
  output logic            done_o,
  output logic [DIVb+3:0] c_o,
  output logic [DIVb+3:0] u_o,
  output logic [DIVb+3:0] um_o
);

  localparam int unsigned W = DIVb + 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNTW-1:0] MaxIter = CNTW'(DIVb / 2);
  // First digit pair sits just below the binary point.
  localparam logic [W-1:0]    CInit   = {{6{1'b1}}, {(DIVb - 2){1'b0}}};
  localparam logic [W-1:0]    OneQ    = {4'b0001, {DIVb{1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, iter_clamped;
  logic [W-1:0]    u_q, u_d, um_q, um_d, c_q, c_d;
  logic [W-1:0]    k1, k2, k3;
  logic            launch, step;

  assign launch = (state_q == StIdle) & start_i & ~flush_i;
  assign step   = (state_q == StBusy) & ~flush_i;

  // LSB of the current digit pair, the bit above it, and both together.
  assign k1 = c_q & ~(c_q << 1);
  assign k2 = k1 << 1;
  assign k3 = k1 | k2;

  // Requested step count, forced into 1..DIVb/2.
  always_comb begin
    if (num_iter_i == '0) begin
      iter_clamped = CNTW'(1);
    end else if (num_iter_i > MaxIter) begin
      iter_clamped = MaxIter;
    end else begin
      iter_clamped = num_iter_i;
    end
  end

  // On-the-fly conversion and mask advance; udigit priority is [3] > [2] > [1] > [0].
  always_comb begin
    u_d  = u_q;
    um_d = um_q;
    c_d  = c_q;
    if (launch) begin
      c_d  = CInit;
      u_d  = sqrt_e_i ? OneQ : '0;
      um_d = '0;
    end else if (step) begin
      c_d = {2'b11, c_q[W-1:2]};
      if (udigit_i[3]) begin        // +2
        u_d  = u_q | k2;
        um_d = u_q | k1;
      end else if (udigit_i[2]) begin // +1
        u_d  = u_q | k1;
        um_d = u_q;
      end else if (udigit_i[1]) begin // -1
        u_d  = um_q | k3;
        um_d = um_q | k2;
      end else if (udigit_i[0]) begin // -2
        u_d  = um_q | k2;
        um_d = um_q | k1;
      end else begin                  // 0
        u_d  = u_q;
        um_d = um_q | k3;
      end
    end
  end

  // Sequencer next state; Flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StBusy;
            cnt_d   = iter_clamped;
          end
        end
        StBusy: begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      u_q     <= '0;
      um_q    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      um_q    <= um_d;
      c_q     <= c_d;
    end
  end

  assign busy_o = (state_q == StBusy);
  assign step_o = step;
  assign done_o = (state_q == StDone) & ~flush_i;
  assign c_o    = c_q;
  assign u_o    = u_q;
  assign um_o   = um_q;

endmodule

// File: tb/tb_fdivsqrt_r4_seq.sv
// Directed bench for fdivsqrt_r4_seq (DIVb=8): per-cycle comparison against a
// step-indexed model plus hand-computed literal results.
module tb_fdivsqrt_r4_seq;

  localparam int unsigned DIVb = 8;
  localparam int unsigned CNTW = 6;

  logic            clk, reset, start, sqrt_e, flush;
  logic [CNTW-1:0] num_iter;
  logic [3:0]      udigit;
  logic            busy, step, done;
  logic [11:0]     c, u, um;

  int n_checks = 0;
  int n_err    = 0;
  int step_cnt = 0;
  int done_cnt = 0;
  int s0, d0;

  // Model: 0 idle, 1 busy, 2 done; m_idx is the 1-based index of the next digit.
  int          m_st  = 0;
  int          m_rem = 0;
  int          m_idx = 0;
  logic [11:0] m_u   = '0;
  logic [11:0] m_um  = '0;
  logic [11:0] m_c   = '0;

  fdivsqrt_r4_seq #(.DIVb(DIVb), .CNTW(CNTW)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .sqrt_e_i   (sqrt_e),
    .num_iter_i (num_iter),
    .flush_i    (flush),
    .udigit_i   (udigit),
    .busy_o     (busy),
    .step_o     (step),
    .done_o     (done),
    .c_o        (c),
    .u_o        (u),
    .um_o       (um)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mask of digit positions already consumed before digit i (ones from bit DIVb-2i up).
  function automatic logic [11:0] cmask(input int i);
    logic [11:0] one;
    int p;
    one = 12'h001;
    p = int'(DIVb) - 2 * i;
    if (p < 0) return 12'hFFF;
    return ~((one << p) - one);
  endfunction

  // Result update for digit number idx: value of the digit is placed at weight 4^-idx.
  function automatic logic [23:0] otf(input logic [11:0] uu, input logic [11:0] mm,
                                      input int idx, input logic [3:0] dig);
    logic [11:0] k1, k2, k3;
    k1 = 12'h001 << (int'(DIVb) - 2 * idx);
    k2 = k1 << 1;
    k3 = k1 | k2;
    if (dig[3])      return {uu | k2, uu | k1};
    else if (dig[2]) return {uu | k1, uu};
    else if (dig[1]) return {mm | k3, mm | k2};
    else if (dig[0]) return {mm | k2, mm | k1};
    else             return {uu, mm | k3};
  endfunction

  // Reference model update.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_rem <= 0; m_idx <= 0;
      m_u <= '0; m_um <= '0; m_c <= '0;
    end else if (flush) begin
      m_st <= 0; m_rem <= 0;
    end else begin
      case (m_st)
        0: if (start) begin
          m_st  <= 1;
          m_rem <= (num_iter == 0) ? 1 : (int'(num_iter) > int'(DIVb / 2)) ? int'(DIVb / 2)
                                                                         : int'(num_iter);
          m_idx <= 1;
          m_u   <= sqrt_e ? 12'h100 : 12'h000;
          m_um  <= 12'h000;
          m_c   <= cmask(1);
        end
        1: begin
          {m_u, m_um} <= otf(m_u, m_um, m_idx, udigit);
          m_c   <= cmask(m_idx + 1);
          m_idx <= m_idx + 1;
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_st <= 2;
        end
        default: m_st <= 0;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy", {11'd0, busy}, {11'd0, m_st == 1});
    check("step", {11'd0, step}, {11'd0, (m_st == 1) && !flush});
    check("done", {11'd0, done}, {11'd0, (m_st == 2) && !flush});
    check("u",    u,  m_u);
    check("um",   um, m_um);
    check("c",    c,  m_c);
    if (step) step_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic s, input logic [CNTW-1:0] n);
    start = 1'b1; sqrt_e = s; num_iter = n;
    tick();
    start = 1'b0;
  endtask

  task automatic apply(input logic [3:0] d);
    udigit = d;
    tick();
    udigit = 4'b0000;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {11'd0, busy}, 12'h000);
    check({tag, "_step"}, {11'd0, step}, 12'h000);
    check({tag, "_done"}, {11'd0, done}, 12'h000);
    check({tag, "_u"},  u,  12'h000);
    check({tag, "_um"}, um, 12'h000);
    check({tag, "_c"},  c,  12'h000);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sqrt_e = 1'b0; num_iter = '0; flush = 1'b0; udigit = '0;
    #1 reset = 1'b1;
    #1 check_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Divide, digits +1 +2 0 -1 -> 0.0101 1111 = 95/256.
    s0 = step_cnt; d0 = done_cnt;
    start_op(1'b0, 6'd4);
    apply(4'b0100); apply(4'b1000); apply(4'b0000); apply(4'b0010);
    check("div_done_pulse", {11'd0, done}, 12'h001);
    check("div_u",  u,  12'h05F);
    check("div_um", um, 12'h05E);
    check("div_c",  c,  12'hFFF);
    tick();
    check("div_steps", 12'(step_cnt - s0), 12'd4);
    check("div_dones", 12'(done_cnt - d0), 12'd1);

    // Sqrt, digits -2 +1.
    start_op(1'b1, 6'd2);
    check("sqrt_c0", c, 12'hFC0);
    check("sqrt_u0", u, 12'h100);
    apply(4'b0001);
    check("sqrt_u1",  u,  12'h080);
    check("sqrt_um1", um, 12'h040);
    check("sqrt_c1",  c,  12'hFF0);
    apply(4'b0100);
    check("sqrt_u2", u, 12'h090);
    check("sqrt_c2", c, 12'hFFC);
    tick();

    // Flush on second busy cycle with Start also high.
    s0 = step_cnt; d0 = done_cnt;
    start_op(1'b0, 6'd4);
    apply(4'b0100);
    flush = 1'b1; start = 1'b1; udigit = 4'b1000;
    #1 check("flush_step", {11'd0, step}, 12'h000);
    tick();
    flush = 1'b0; start = 1'b0; udigit = 4'b0000;
    check("flush_idle", {11'd0, busy}, 12'h000);
    check("flush_u",  u,  12'h040);
    check("flush_um", um, 12'h000);
    tick(); tick();
    check("flush_steps", 12'(step_cnt - s0), 12'd1);
    check("flush_dones", 12'(done_cnt - d0), 12'd0);

    // NumIter=0 behaves as a single step.
    s0 = step_cnt; d0 = done_cnt;
    start_op(1'b0, 6'd0);
    apply(4'b0100);
    tick();
    check("n0_steps", 12'(step_cnt - s0), 12'd1);
    check("n0_dones", 12'(done_cnt - d0), 12'd1);
    check("n0_u", u, 12'h040);

    // NumIter=63 clamps to DIVb/2 = 4 steps.
    s0 = step_cnt; d0 = done_cnt;
    start_op(1'b0, 6'd63);
    repeat (4) apply(4'b0100);
    tick(); tick();
    check("n63_steps", 12'(step_cnt - s0), 12'd4);
    check("n63_dones", 12'(done_cnt - d0), 12'd1);
    check("n63_u", u, 12'h055);

    // Start held through BUSY and DONE does not restart.
    s0 = step_cnt; d0 = done_cnt;
    start = 1'b1; sqrt_e = 1'b0; num_iter = 6'd2;
    tick();
    udigit = 4'b0100;
    tick(); tick();
    udigit = 4'b0000;
    tick();
    start = 1'b0;
    tick();
    check("hold_steps", 12'(step_cnt - s0), 12'd2);
    check("hold_dones", 12'(done_cnt - d0), 12'd1);
    check("hold_idle", {11'd0, busy}, 12'h000);

    // Multi-hot digit resolves to +1, zero digit ORs K3 into UM.
    start_op(1'b0, 6'd2);
    apply(4'b0110);
    check("mh_u",  u,  12'h040);
    check("mh_um", um, 12'h000);
    apply(4'b0000);
    check("zd_u",  u,  12'h040);
    check("zd_um", um, 12'h030);
    tick();

    // Asynchronous reset in the third busy cycle, then a normal operation.
    start_op(1'b0, 6'd4);
    apply(4'b0100); apply(4'b1000);
    #1 reset = 1'b1;
    #1 check_zero("midrst");
    #1 reset = 1'b0;
    tick();
    s0 = step_cnt; d0 = done_cnt;
    start_op(1'b1, 6'd1);
    apply(4'b0100);
    check("post_u",  u,  12'h140);
    check("post_um", um, 12'h100);
    tick();
    check("post_dones", 12'(done_cnt - d0), 12'd1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
